// File: rtl/uart_tx_scheduler.sv
// Transmit-side message scheduler: tracks pending game-state messages, arbitrates them,
// and serialises each one into {payload[4:0], opcode[2:0]} frames for the UART TX FIFO.
module uart_tx_scheduler #(
  parameter int unsigned SYNC_PERIOD = 650000,
  parameter int unsigned BYTE_GAP    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       game_starts,
  input  logic       local_shooter,
  input  logic [9:0] keeper_pos,
  input  logic [9:0] x_shooter,
  input  logic [9:0] y_shooter,
  input  logic       shot_req,
  input  logic [2:0] score,
  input  logic       is_shooted,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic       busy
);

  localparam int unsigned SyncW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int unsigned GapW  = $clog2(BYTE_GAP + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;
  typedef enum logic [1:0] {MsgSync, MsgScore, MsgShot, MsgKeeper} msg_e;

  state_e           state_q, state_d;
  msg_e             msg_q, msg_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic             sync_pend_q, sync_pend_d;
  logic             score_pend_q, score_pend_d;
  logic             shot_pend_q, shot_pend_d;
  logic             keeper_pend_q, keeper_pend_d;
  logic [9:0]       last_keeper_q, last_keeper_d;
  logic [2:0]       last_score_q, last_score_d;
  logic             last_shooted_q, last_shooted_d;
  logic [31:0]      frames_q, frames_d;
  logic [1:0]       bytes_left_q, bytes_left_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             busy_q, busy_d;
  logic             sync_hit;

  // frames_q is a shift register; the byte being offered always sits in the low lane.
  assign w_data  = frames_q[7:0];
  assign wr_uart = (state_q == StSend) && !tx_full;
  assign busy    = busy_q;

  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    sync_cnt_d     = sync_cnt_q + 1'b1;
    sync_hit       = 1'b0;
    last_keeper_d  = last_keeper_q;
    last_score_d   = last_score_q;
    last_shooted_d = last_shooted_q;
    frames_d       = frames_q;
    bytes_left_d   = bytes_left_q;
    gap_cnt_d      = gap_cnt_q;
    busy_d         = busy_q;

    if (sync_cnt_q == SyncW'(SYNC_PERIOD - 1)) begin
      sync_cnt_d = '0;
      sync_hit   = 1'b1;
    end

    sync_pend_d   = sync_pend_q | sync_hit;
    score_pend_d  = score_pend_q | ({is_shooted, score} != {last_shooted_q, last_score_q});
    // A shot request during a shot message folds into the one already being sent.
    shot_pend_d   = shot_pend_q | (shot_req & ~(busy_q & (msg_q == MsgShot)));
    keeper_pend_d = keeper_pend_q | (keeper_pos != last_keeper_q);

    unique case (state_q)
      StIdle: begin
        if (tx_en && (sync_pend_q || score_pend_q || shot_pend_q || keeper_pend_q)) begin
          state_d = StLoad;
          busy_d  = 1'b1;
          if (sync_pend_q)       msg_d = MsgSync;
          else if (score_pend_q) msg_d = MsgScore;
          else if (shot_pend_q)  msg_d = MsgShot;
          else                   msg_d = MsgKeeper;
        end
      end
      StLoad: begin
        state_d = StSend;
        unique case (msg_q)
          MsgSync: begin
            frames_d     = {24'h0, local_shooter & game_starts, game_starts, 6'b001000};
            bytes_left_d = 2'd0;
            sync_pend_d  = 1'b0;
          end
          MsgScore: begin
            frames_d       = {24'h0, 1'b0, is_shooted, score, 3'b111};
            bytes_left_d   = 2'd0;
            last_score_d   = score;
            last_shooted_d = is_shooted;
            score_pend_d   = 1'b0;
          end
          MsgShot: begin
            frames_d     = {y_shooter[9:5], 3'b110, y_shooter[4:0], 3'b101,
                            x_shooter[9:5], 3'b100, x_shooter[4:0], 3'b011};
            bytes_left_d = 2'd3;
            shot_pend_d  = 1'b0;
          end
          MsgKeeper: begin
            frames_d      = {16'h0, keeper_pos[9:5], 3'b010, keeper_pos[4:0], 3'b001};
            bytes_left_d  = 2'd1;
            last_keeper_d = keeper_pos;
            keeper_pend_d = 1'b0;
          end
          default: ;
        endcase
      end
      StSend: begin
        if (!tx_full) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(BYTE_GAP - 1)) begin
          if (bytes_left_q == 2'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d      = StSend;
            bytes_left_d = bytes_left_q - 1'b1;
            frames_d     = {8'h0, frames_q[31:8]};
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      msg_q          <= MsgSync;
      sync_cnt_q     <= '0;
      sync_pend_q    <= 1'b0;
      score_pend_q   <= 1'b0;
      shot_pend_q    <= 1'b0;
      keeper_pend_q  <= 1'b0;
      last_keeper_q  <= '0;
      last_score_q   <= '0;
      last_shooted_q <= 1'b0;
      frames_q       <= '0;
      bytes_left_q   <= '0;
      gap_cnt_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      msg_q          <= msg_d;
      sync_cnt_q     <= sync_cnt_d;
      sync_pend_q    <= sync_pend_d;
      score_pend_q   <= score_pend_d;
      shot_pend_q    <= shot_pend_d;
      keeper_pend_q  <= keeper_pend_d;
      last_keeper_q  <= last_keeper_d;
      last_score_q   <= last_score_d;
      last_shooted_q <= last_shooted_d;
      frames_q       <= frames_d;
      bytes_left_q   <= bytes_left_d;
      gap_cnt_q      <= gap_cnt_d;
      busy_q         <= busy_d;
    end
  end

endmodule
